// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the sprite mappers and the DAC.
// master drives the bundle; mappers and DAC connect through slave.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       sync;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, sync, frame_start, frame_count
  );
  modport slave (
    input DrawX, DrawY, hs, vs, blank, sync, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel/line counters, active-low syncs, blank qualifier.
// Optional macro VGA_PIPE_ALIGN_EN delays hs/vs/blank by PIPE_DEPTH clocks to match mapper colour latency.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam logic [9:0] H_TOTAL  = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOTAL  = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

  if (PIPE_DEPTH < 1) begin : g_pipe_depth_check
    $error("vga_timing_gen: PIPE_DEPTH must be at least 1");
  end

  logic [9:0] draw_x, draw_y;
  logic [9:0] x_next, y_next;
  logic       x_wrap, y_wrap, frame_wrap;
  logic       hs_d, vs_d, blank_d;
  logic       hs_r, vs_r, blank_r;
  logic       frame_start_r;
  logic [7:0] frame_count_r;

  // Decode from the next-state counters so registered flags line up with DrawX/DrawY.
  always_comb begin
    x_wrap     = (draw_x == H_TOTAL - 10'd1);
    y_wrap     = (draw_y == V_TOTAL - 10'd1);
    frame_wrap = x_wrap && y_wrap;
    x_next     = x_wrap ? 10'd0 : draw_x + 10'd1;
    y_next     = draw_y;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : draw_y + 10'd1;
    end
    hs_d    = !((x_next >= HS_START) && (x_next <= HS_END));
    vs_d    = !((y_next >= VS_START) && (y_next <= VS_END));
    blank_d = (x_next < H_VIS) && (y_next < V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x        <= '0;
      draw_y        <= '0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_r       <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= '0;
    end else begin
      draw_x        <= x_next;
      draw_y        <= y_next;
      hs_r          <= hs_d;
      vs_r          <= vs_d;
      blank_r       <= blank_d;
      frame_start_r <= frame_wrap;
      if (frame_wrap) begin
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic [PIPE_DEPTH-1:0] hs_pipe, vs_pipe, blank_pipe;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      blank_pipe <= '0;
    end else begin
      hs_pipe[0]    <= hs_r;
      vs_pipe[0]    <= vs_r;
      blank_pipe[0] <= blank_r;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
        blank_pipe[i] <= blank_pipe[i-1];
      end
    end
  end

  assign vga.hs    = hs_pipe[PIPE_DEPTH-1];
  assign vga.vs    = vs_pipe[PIPE_DEPTH-1];
  assign vga.blank = blank_pipe[PIPE_DEPTH-1];
`else
  assign vga.hs    = hs_r;
  assign vga.vs    = vs_r;
  assign vga.blank = blank_r;
`endif

  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.sync        = 1'b0;
  assign vga.frame_start = frame_start_r;
  assign vga.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-timing instance runs 257 frames, a default instance checks 640x480 line timing.
module tb_vga_timing_gen;

  localparam int SH_V = 8, SH_FP = 2, SH_SY = 3, SH_BP = 2;
  localparam int SV_V = 5, SV_FP = 1, SV_SY = 2, SV_BP = 1;
  localparam int SHT  = SH_V + SH_FP + SH_SY + SH_BP;
  localparam int SVT  = SV_V + SV_FP + SV_SY + SV_BP;
  localparam int SFT  = SHT * SVT;
`ifdef VGA_PIPE_ALIGN_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if s_if ();
  vga_timing_gen_if d_if ();

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_SY), .H_BP(SH_BP),
    .V_VISIBLE(SV_V), .V_FP(SV_FP), .V_SYNC(SV_SY), .V_BP(SV_BP),
    .PIPE_DEPTH(2)
  ) u_small (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .vga(s_if)
  );

  vga_timing_gen u_def (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .vga(d_if)
  );

  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  obs_t q_s[$];
  obs_t q_d[$];

  // Reference: position purely from edges elapsed since reset release.
  function automatic obs_t model(input int kk, input int hv, input int hf, input int hsy, input int hb,
                                 input int vv, input int vf, input int vsy, input int vb, input int lag);
    obs_t r;
    int ht, vt, ft, j, jx, jy;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    ft = ht * vt;
    r.x    = 10'(kk % ht);
    r.y    = 10'((kk / ht) % vt);
    r.sync = 1'b0;
    r.fs   = (kk > 0) && (kk % ft == 0);
    r.fc   = 8'((kk / ft) % 256);
    j = kk - lag;
    if (j < 1) begin
      r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0;
    end else begin
      jx = j % ht;
      jy = (j / ht) % vt;
      r.hs    = !(jx >= hv + hf && jx < hv + hf + hsy);
      r.vs    = !(jy >= vv + vf && jy < vv + vf + vsy);
      r.blank = (jx < hv) && (jy < vv);
    end
    return r;
  endfunction

  function automatic obs_t get_s();
    obs_t o;
    o.x = s_if.DrawX; o.y = s_if.DrawY; o.hs = s_if.hs; o.vs = s_if.vs; o.blank = s_if.blank;
    o.sync = s_if.sync; o.fs = s_if.frame_start; o.fc = s_if.frame_count;
    return o;
  endfunction

  function automatic obs_t get_d();
    obs_t o;
    o.x = d_if.DrawX; o.y = d_if.DrawY; o.hs = d_if.hs; o.vs = d_if.vs; o.blank = d_if.blank;
    o.sync = d_if.sync; o.fs = d_if.frame_start; o.fc = d_if.frame_count;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic push_expected();
    q_s.push_back(model(k, SH_V, SH_FP, SH_SY, SH_BP, SV_V, SV_FP, SV_SY, SV_BP, LAG));
    q_d.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, LAG));
  endtask

  task automatic pop_compare();
    obs_t e;
    e = q_s.pop_front();
    chk("sb_small", 40'(get_s()), 40'(e));
    e = q_d.pop_front();
    chk("sb_default", 40'(get_d()), 40'(e));
  endtask

  task automatic step(input bit in_rst);
    if (in_rst) k = 0; else k++;
    push_expected();
    @(posedge vga_clk);
    #1;
    pop_compare();
  endtask

  int s_hs_lo[2], s_vs_lo[2], s_bl[2], s_fs[2];
  int d_hs_lo = 0, d_hs_x = -1, d_bl_x = -1;
  int s_vs_x = -1, s_vs_y = -1;
  logic d_prev_bl = 1'b0;
  int w, guard;

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_hs_lo[i] = 0; s_vs_lo[i] = 0; s_bl[i] = 0; s_fs[i] = 0;
    end
    reset_n = 1'b0;
    repeat (5) step(1'b1);
    @(negedge vga_clk);
    reset_n = 1'b1;

    step(1'b0);
    chk("first_drawx", 40'(s_if.DrawX), 40'(10'd1));
    chk("first_blank", 40'(s_if.blank), 40'(LAG == 0));

    while (k < 257 * SFT + 10) begin
      step(1'b0);
      if (k >= SFT && k < 3 * SFT) begin
        w = k / SFT - 1;
        s_hs_lo[w] += int'(!s_if.hs);
        s_vs_lo[w] += int'(!s_if.vs);
        s_bl[w]    += int'(s_if.blank);
        s_fs[w]    += int'(s_if.frame_start);
      end
      if (s_vs_x < 0 && !s_if.vs) begin
        s_vs_x = int'(s_if.DrawX);
        s_vs_y = int'(s_if.DrawY);
      end
      if (k >= 800 && k < 1600) d_hs_lo += int'(!d_if.hs);
      if (d_hs_x < 0 && !d_if.hs) d_hs_x = int'(d_if.DrawX);
      if (d_bl_x < 0 && d_prev_bl && !d_if.blank) d_bl_x = int'(d_if.DrawX);
      d_prev_bl = d_if.blank;
      if (k == 256 * SFT) chk("fc_rollover_0", 40'(s_if.frame_count), 40'(8'd0));
      if (k == 257 * SFT) begin
        chk("fc_frame_257", 40'(s_if.frame_count), 40'(8'd1));
        chk("fs_frame_257", 40'(s_if.frame_start), 40'(1'b1));
      end
    end

    for (int i = 0; i < 2; i++) begin
      chk("hs_low_per_frame", 40'(s_hs_lo[i]), 40'(SH_SY * SVT));
      chk("vs_low_per_frame", 40'(s_vs_lo[i]), 40'(SV_SY * SHT));
      chk("blank_per_frame", 40'(s_bl[i]), 40'(SH_V * SV_V));
      chk("fs_per_frame", 40'(s_fs[i]), 40'(1));
    end
    chk("vs_first_x", 40'(s_vs_x), 40'(LAG));
    chk("vs_first_y", 40'(s_vs_y), 40'(SV_V + SV_FP));
    chk("def_hs_low_line", 40'(d_hs_lo), 40'(96));
    chk("def_hs_fall_x", 40'(d_hs_x), 40'(656 + LAG));
    chk("def_blank_fall_x", 40'(d_bl_x), 40'(640 + LAG));

    // Mid-frame asynchronous reset at small-raster pixel (5,4).
    guard = 0;
    while (k % SFT != 4 * SHT + 5 && guard < 2 * SFT) begin
      step(1'b0);
      guard++;
    end
    chk("midframe_reach", 40'(k % SFT), 40'(4 * SHT + 5));
    #2;
    reset_n = 1'b0;
    k = 0;
    #1;
    push_expected();
    pop_compare();
    step(1'b1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (SFT + 5) step(1'b0);
    chk("fc_after_restart", 40'(s_if.frame_count), 40'(8'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 VGA raster timing on `vga_clk`, producing the `DrawX`/`DrawY` pixel coordinates and the `blank` qualifier consumed by every sprite mapper, plus the active-low `hs`/`vs` syncs driven to the DAC/connector. It sits upstream of all mappers: each mapper converts (`DrawX`, `DrawY`) into a ROM address and registers its colour while `blank` is high. An optional sync-delay pipeline re-aligns `hs`/`vs`/`blank` with the mappers' colour latency.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIPE_DEPTH`, 2, sync-delay stages; ≥1; used only with `VGA_PIPE_ALIGN_EN`
- `vga_clk`  in  1  pixel clock, single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  horizontal counter, 0..H_TOTAL-1
- `DrawY`  out  10  vertical counter, 0..V_TOTAL-1
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `blank`  out  1  1 = visible pixel, 0 = blanking
- `sync`  out  1  composite sync to DAC, constant 0
- `frame_start`  out  1  one-cycle pulse at (0,0)
- `frame_count`  out  8  completed-frame counter

## Operation
- Totals: H_TOTAL = sum of the H parameters = 800; V_TOTAL = sum of the V parameters = 525.
- `DrawX` increments every `vga_clk`. At H_TOTAL-1 it wraps to 0 and `DrawY` increments. `DrawY` wraps to 0 when it is at V_TOTAL-1 and `DrawX` wraps.
- `hs` = 0 iff `DrawX` ∈ [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656, 751].
- `vs` = 0 iff `DrawY` ∈ [490, 491], computed the same way.
- `blank` = 1 iff `DrawX` < H_VISIBLE and `DrawY` < V_VISIBLE.
- `hs`, `vs`, `blank` and `frame_start` are registered. Each is decoded from the next-state counter values, so it is cycle-aligned with the `DrawX`/`DrawY` it describes.
- `frame_start` = 1 for exactly the cycle in which (`DrawX`, `DrawY`) = (0,0) after a wrap.
- `frame_count` increments in the same cycle as `frame_start` and wraps from 255 to 0.
- Counters, compares and `frame_count` are unsigned with no saturation; all arithmetic is 10-bit.

## Timing
- Reset (`reset_n` low, asynchronous): `DrawX`=0, `DrawY`=0, `hs`=1, `vs`=1, `blank`=0, `frame_start`=0, `frame_count`=0, and all delay stages cleared to (hs=1, vs=1, blank=0).
- First edge after release: `DrawX`=1, `blank`=1. Pixel (0,0) of the first post-reset frame is blanked, and that frame raises no `frame_start`.
- Reset mid-frame: counters return to (0,0) immediately. No partial-frame increment of `frame_count`.
- Line period is 800 clocks; frame period is 420 000 clocks.
- `vs` edges coincide with `DrawX`=0 edges; `vs` asserts on the cycle `DrawY` becomes 490.
- Simultaneous H and V wrap at (799,524) → (0,0) occurs in one cycle, together with the `frame_start` pulse and the `frame_count` increment.
- `DrawX`/`DrawY` are never delayed, in either configuration.

## Configuration
- `VGA_PIPE_ALIGN_EN` defined:
  - `hs`, `vs`, `blank` pass through a PIPE_DEPTH-stage shift register before the outputs, so they lag `DrawX`/`DrawY` by PIPE_DEPTH clocks.
  - With the default of 2, this matches a mapper's ROM read plus colour register.
  - `frame_start` and `frame_count` are not delayed.
- Undefined: no delay stages, zero lag, and `PIPE_DEPTH` is ignored.

## Test plan
- Hold `reset_n` low 5 clocks, release, run 1 frame → outputs match the reset values while low; `DrawX`=1, `blank`=1 one edge after release; `DrawX` wraps 799→0.
- Run 2 full frames, count cycles → `hs` low for exactly 96 clocks per line, starting at `DrawX`=656; `vs` low for exactly 1600 clocks per frame, starting at (0,490).
- Count `blank`=1 cycles per frame → 307 200. `blank` falls at `DrawX`=640 and at `DrawY`=480.
- Run 257 frames → `frame_start` pulses once per frame, each time at (0,0); `frame_count` reads 0 after frame 256 rolls over.
- Assert `reset_n` at (300,200) for 1 clock → asynchronous return to the reset values; next frame starts from (0,0) with `frame_count` unchanged at 0.
- With `VGA_PIPE_ALIGN_EN` defined, `PIPE_DEPTH`=2 → `hs` falls at `DrawX`=658 and `blank` falls at `DrawX`=642; `DrawX`/`DrawY` identical to the undefined build.
